// File: rtl/image_filter_top.sv
// -----------------------------------------------------------------------------
// image_filter_top
// Streaming 3x3 convolution filter for square 8-bit grayscale frames.
//   clk / rst_n        : single clock; rst_n is an asynchronous ACTIVE-HIGH reset
//   s_axis_*           : input pixels (tuser/tlast are ignored; counters track
//                        position inside the frame)
//   m_axis_*           : filtered pixels, tuser = end of row, tlast = end of frame
//   s_axi_control_*    : AXI4-Lite control port
//                        0x0 CTRL (bit0 start), 0x4 STATUS (0 idle/1 busy/2 done),
//                        0x8 FILTER (nine 3-bit weights, W1 in [2:0])
// Output row r is emitted while input row r+2 streams in. Output column c is
// computed one cycle after input column c+1 is accepted; the last column of a
// row is computed by an extra "flush" step that shifts a zero column in.
// -----------------------------------------------------------------------------
module image_filter_top #(
  parameter int AXI_CONTROL_DATA_WIDTH = 32,
  parameter int AXI_CONTROL_ADDR_WIDTH = 4,
  parameter int AXIS_DATA_WIDTH        = 8,
  parameter int IMAGE_WIDTH_SIZE       = 512,
  parameter int IMAGE_WIDTH_LOG2_SIZE  = 9,
  parameter int FIFO_DEPTH             = 4,
  parameter int FIFO_LOG2_DEPTH        = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                              s_axis_tuser,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tlast,
  input  logic [AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_awaddr,
  input  logic                              s_axi_control_awvalid,
  output logic                              s_axi_control_awready,
  input  logic [AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_wdata,
  input  logic                              s_axi_control_wvalid,
  output logic                              s_axi_control_wready,
  output logic [1:0]                        s_axi_control_bresp,
  output logic                              s_axi_control_bvalid,
  input  logic                              s_axi_control_bready,
  input  logic [AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_araddr,
  input  logic                              s_axi_control_arvalid,
  output logic                              s_axi_control_arready,
  output logic [AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_rdata,
  output logic [1:0]                        s_axi_control_rresp,
  output logic                              s_axi_control_rvalid,
  input  logic                              s_axi_control_rready
);
  localparam int DW    = AXIS_DATA_WIDTH;
  localparam int AW    = AXI_CONTROL_ADDR_WIDTH;
  localparam int CW    = AXI_CONTROL_DATA_WIDTH;
  localparam int LW    = IMAGE_WIDTH_LOG2_SIZE;
  localparam int FL    = FIFO_LOG2_DEPTH;
  localparam int ACC_W = DW + 7;  // 9 * 255 * 7 = 16065 fits in 15 bits
  localparam logic [AW-1:0] ADDR_CTRL   = AW'(4'h0);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(4'h4);
  localparam logic [AW-1:0] ADDR_FILTER = AW'(4'h8);
  localparam logic [LW-1:0] COL_LAST    = LW'(IMAGE_WIDTH_SIZE - 1);
  localparam logic [DW-1:0] PIX_MAX     = '1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
  // Window column: [0] = row r (oldest), [1] = row r+1, [2] = row r+2 (incoming).
  typedef logic [2:0][DW-1:0] column_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ctrl_q, ctrl_d, rdata_q, rdata_d;
  logic [26:0]     filter_q, filter_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic            aw_latched_q, aw_latched_d, awready_q, awready_d, wready_q, wready_d;
  logic            bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [LW-1:0]   col_q, col_d, row_q, row_d, calc_col_q, calc_col_d;
  column_t [2:0]   win_q, win_d;  // [0] = column c-1, [1] = c, [2] = c+1
  logic            calc_v_q, calc_v_d, last_row_q, last_row_d, flush_q, flush_d;
  logic [FL-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FL:0]     count_q, count_d;

  logic [DW-1:0]   line0_q [IMAGE_WIDTH_SIZE];  // row r   (two rows back)
  logic [DW-1:0]   line1_q [IMAGE_WIDTH_SIZE];  // row r+1 (one row back)
  logic [DW-1:0]   fifo_data_q [FIFO_DEPTH];
  logic            fifo_user_q [FIFO_DEPTH];
  logic            fifo_last_q [FIFO_DEPTH];

  logic            aw_hs, w_hs, ar_hs, s_hs, m_hs, start_req, wr_ctrl;
  logic [ACC_W-1:0] sum, shifted;
  logic [DW-1:0]   result;
  logic            unused_inputs;

  assign unused_inputs = &{1'b0, s_axis_tuser, s_axis_tlast};

  assign aw_hs     = s_axi_control_awvalid && awready_q;
  assign w_hs      = s_axi_control_wvalid && wready_q;
  assign ar_hs     = s_axi_control_arvalid && arready_q;
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign wr_ctrl   = w_hs && (awaddr_q == ADDR_CTRL);
  assign start_req = wr_ctrl && s_axi_control_wdata[0] && (state_q == ST_IDLE);

  // Accept only when the FIFO can absorb both results of a row-end pixel,
  // counting the result already computed this cycle; never during a flush.
  assign s_axis_tready = (state_q == ST_BUSY) && !flush_q &&
                         ((count_q + (FL+1)'(calc_v_q)) <= (FL+1)'(FIFO_DEPTH - 2));

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
  assign m_axis_tuser  = fifo_user_q[rd_ptr_q];
  assign m_axis_tlast  = fifo_last_q[rd_ptr_q];

  assign s_axi_control_awready = awready_q;
  assign s_axi_control_wready  = wready_q;
  assign s_axi_control_bvalid  = bvalid_q;
  assign s_axi_control_bresp   = 2'b00;
  assign s_axi_control_arready = arready_q;
  assign s_axi_control_rvalid  = rvalid_q;
  assign s_axi_control_rdata   = rdata_q;
  assign s_axi_control_rresp   = 2'b00;

  // Control registers, AXI-Lite handshakes and FSM.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    filter_d     = filter_q;
    awaddr_d     = awaddr_q;
    aw_latched_d = aw_latched_q;
    rdata_d      = rdata_q;
    // Ready strobes are single-cycle pulses; a master holding valid afterwards
    // cannot re-trigger until the current write/read has fully completed.
    awready_d    = s_axi_control_awvalid && !aw_latched_q && !awready_q && !bvalid_q;
    wready_d     = s_axi_control_wvalid && aw_latched_q && !wready_q;
    arready_d    = s_axi_control_arvalid && !arready_q && !rvalid_q;
    bvalid_d     = bvalid_q && !s_axi_control_bready;
    rvalid_d     = rvalid_q && !s_axi_control_rready;

    if (aw_hs) begin
      awaddr_d     = s_axi_control_awaddr;
      aw_latched_d = 1'b1;
    end
    if (w_hs) begin
      aw_latched_d = 1'b0;
      bvalid_d     = 1'b1;
      if (awaddr_q == ADDR_CTRL)   ctrl_d   = s_axi_control_wdata;
      if (awaddr_q == ADDR_FILTER) filter_d = s_axi_control_wdata[26:0];
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      unique case (s_axi_control_araddr)
        ADDR_CTRL:   rdata_d = ctrl_q;
        ADDR_STATUS: rdata_d = CW'(state_q);
        ADDR_FILTER: rdata_d = CW'(filter_q);
        default:     rdata_d = '0;
      endcase
    end

    unique case (state_q)
      ST_IDLE: if (start_req) state_d = ST_BUSY;
      ST_BUSY: if (m_hs && m_axis_tlast) state_d = ST_DONE;
      ST_DONE: if (wr_ctrl && !s_axi_control_wdata[0]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Window shifting, position counters and FIFO bookkeeping.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    win_d      = win_q;
    calc_v_d   = 1'b0;
    calc_col_d = calc_col_q;
    last_row_d = last_row_q;
    flush_d    = 1'b0;
    if (start_req) begin
      col_d      = '0;
      row_d      = '0;
      win_d      = '0;
      last_row_d = 1'b0;
    end else if (s_hs) begin
      win_d[0]   = win_q[1];
      win_d[1]   = win_q[2];
      win_d[2]   = {s_axis_tdata, line1_q[col_q], line0_q[col_q]};
      calc_v_d   = (row_q >= LW'(2)) && (col_q != '0);
      calc_col_d = col_q - LW'(1);
      last_row_d = (row_q == COL_LAST);
      flush_d    = (row_q >= LW'(2)) && (col_q == COL_LAST);
      col_d      = (col_q == COL_LAST) ? '0 : col_q + LW'(1);
      if (col_q == COL_LAST) row_d = (row_q == COL_LAST) ? '0 : row_q + LW'(1);
    end else if (flush_q) begin
      // Right neighbour of the last column lies outside the frame: shift in zeros.
      win_d[0]   = win_q[1];
      win_d[1]   = win_q[2];
      win_d[2]   = '0;
      calc_v_d   = 1'b1;
      calc_col_d = COL_LAST;
    end

    wr_ptr_d = calc_v_q ? wr_ptr_q + FL'(1) : wr_ptr_q;
    rd_ptr_d = m_hs ? rd_ptr_q + FL'(1) : rd_ptr_q;
    count_d  = count_q + (FL+1)'(calc_v_q) - (FL+1)'(m_hs);
  end

  // Weighted sum; the left column is masked at c = 0 (outside the frame).
  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(j == 0 && calc_col_q == '0))
          sum = sum + ACC_W'(filter_q[3*(i*3+j) +: 3]) * ACC_W'(win_q[j][i]);
      end
    end
    shifted = sum >> 4;
    result  = (shifted > ACC_W'(PIX_MAX)) ? PIX_MAX : shifted[DW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      filter_q     <= '0;
      awaddr_q     <= '0;
      aw_latched_q <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      calc_v_q     <= 1'b0;
      calc_col_q   <= '0;
      last_row_q   <= 1'b0;
      flush_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      filter_q     <= filter_d;
      awaddr_q     <= awaddr_d;
      aw_latched_q <= aw_latched_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      calc_v_q     <= calc_v_d;
      calc_col_q   <= calc_col_d;
      last_row_q   <= last_row_d;
      flush_q      <= flush_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: these arrays are cleared on reset, so they map to flops, not RAM macros.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n || start_req) begin
      for (int i = 0; i < IMAGE_WIDTH_SIZE; i++) begin
        line0_q[i] <= '0;
        line1_q[i] <= '0;
      end
    end else if (s_hs) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_user_q[i] <= 1'b0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (calc_v_q) begin
      fifo_data_q[wr_ptr_q] <= result;
      fifo_user_q[wr_ptr_q] <= (calc_col_q == COL_LAST);
      fifo_last_q[wr_ptr_q] <= (calc_col_q == COL_LAST) && last_row_q;
    end
  end
endmodule

// File: tb/tb_image_filter_top.sv
// -----------------------------------------------------------------------------
// tb_image_filter_top
// Directed bench for image_filter_top, built with an 8x8 frame so whole frames
// run quickly. Expected pixels are hand constants for flat frames and a direct
// convolution model for the random frame.
// -----------------------------------------------------------------------------
module tb_image_filter_top;
  localparam int W  = 8;
  localparam int LW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [7:0]  s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  image_filter_top #(
    .AXI_CONTROL_DATA_WIDTH(32), .AXI_CONTROL_ADDR_WIDTH(4), .AXIS_DATA_WIDTH(8),
    .IMAGE_WIDTH_SIZE(W), .IMAGE_WIDTH_LOG2_SIZE(LW), .FIFO_DEPTH(4), .FIFO_LOG2_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .s_axi_control_awaddr(awaddr), .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_wdata(wdata), .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
    .s_axi_control_bresp(bresp), .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
    .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
    .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp), .s_axi_control_rvalid(rvalid),
    .s_axi_control_rready(rready)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int img [W*W];
  int wts [9];
  int cap_data [$];
  int cap_user [$];
  int cap_last [$];
  bit cap_en = 1'b0;
  bit rand_ready = 1'b0;
  bit sink_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sink: choose tready for the coming edge, then record the transfer it implies.
  always @(negedge clk) begin
    m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : sink_ready;
    if (cap_en && m_axis_tvalid && m_axis_tready) begin
      cap_data.push_back(int'(m_axis_tdata));
      cap_user.push_back(int'(m_axis_tuser));
      cap_last.push_back(int'(m_axis_tlast));
    end
  end

  function automatic int gold(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (c + j - 1 >= 0 && c + j - 1 < W)
          s += wts[i*3+j] * img[(r+i)*W + c + j - 1];
    return ((s >> 4) > 255) ? 255 : (s >> 4);
  endfunction

  function automatic logic [31:0] pack_wts();
    logic [31:0] v = '0;
    for (int k = 0; k < 9; k++) v[3*k +: 3] = 3'(wts[k]);
    return v;
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int g;
    @(negedge clk); awaddr = a; awvalid = 1'b1;
    g = 0; while (!awready && g < 20) begin @(negedge clk); g++; end
    chk("awready", awready, 1);
    @(negedge clk); awvalid = 1'b0; wdata = d; wvalid = 1'b1;
    g = 0; while (!wready && g < 20) begin @(negedge clk); g++; end
    chk("wready", wready, 1);
    @(negedge clk); wvalid = 1'b0; bready = 1'b1;
    g = 0; while (!bvalid && g < 20) begin @(negedge clk); g++; end
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int g;
    @(negedge clk); araddr = a; arvalid = 1'b1;
    g = 0; while (!arready && g < 20) begin @(negedge clk); g++; end
    chk("arready", arready, 1);
    @(negedge clk); arvalid = 1'b0; rready = 1'b1;
    g = 0; while (!rvalid && g < 20) begin @(negedge clk); g++; end
    chk("rvalid", rvalid, 1);
    d = rdata;
    @(negedge clk); rready = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    int g;
    for (int p = 0; p < n; p++) begin
      s_axis_tdata  = 8'(img[p]);
      s_axis_tuser  = (p % W == W - 1);
      s_axis_tlast  = (p == W*W - 1);
      s_axis_tvalid = 1'b1;
      g = 0; while (!s_axis_tready && g < 200) begin @(negedge clk); g++; end
      chk("s_tready", s_axis_tready, 1);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
  endtask

  // mode 0: flat 100 gaussian, 1: saturated, 2: golden model
  task automatic check_frame(input int mode);
    int n_exp = (W - 2) * W;
    int g = 0;
    int e;
    while (cap_data.size() < n_exp && g < 3000) begin @(negedge clk); g++; end
    chk("out_count", cap_data.size(), n_exp);
    for (int idx = 0; idx < cap_data.size() && idx < n_exp; idx++) begin
      int r = idx / W;
      int c = idx % W;
      if (mode == 0)      e = (c == 0 || c == W - 1) ? 75 : 100;
      else if (mode == 1) e = 255;
      else                e = gold(r, c);
      chk($sformatf("data r%0d c%0d", r, c), cap_data[idx], e);
      chk($sformatf("tuser r%0d c%0d", r, c), cap_user[idx], (c == W - 1) ? 1 : 0);
      chk($sformatf("tlast r%0d c%0d", r, c), cap_last[idx], (idx == n_exp - 1) ? 1 : 0);
    end
    cap_data.delete(); cap_user.delete(); cap_last.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] packed_w;
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst m_tvalid", m_axis_tvalid, 0);
    chk("rst s_tready", s_axis_tready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst rdata", rdata, 0);
    axi_read(4'h4, rd); chk("status after reset", rd, 0);
    axi_read(4'h8, rd); chk("filter after reset", rd, 0);

    // Register access
    axi_write(4'h8, 32'h0221221);
    axi_read(4'h8, rd); chk("filter readback", rd, 32'h0221221);
    axi_write(4'hC, 32'hFFFF_FFFF);
    axi_read(4'hC, rd); chk("unmapped read", rd, 0);
    axi_write(4'h8, 32'h0145_4451);  // gaussian 1,2,1 / 2,4,2 / 1,2,1
    axi_read(4'h8, rd); chk("gaussian readback", rd, 32'h0145_4451);

    // Frame 1: flat 100, gaussian, sink always ready
    for (int p = 0; p < W*W; p++) img[p] = 100;
    cap_en = 1'b1; sink_ready = 1'b1;
    axi_write(4'h0, 32'h1);
    axi_read(4'h4, rd); chk("status busy", rd, 1);
    axi_read(4'h0, rd); chk("ctrl readback", rd, 1);
    send_pixels(W*W);
    check_frame(0);
    axi_read(4'h4, rd); chk("status done 1", rd, 2);
    axi_write(4'h0, 32'h0);
    axi_read(4'h4, rd); chk("status idle 1", rd, 0);

    // Frame 2: flat 255, all weights 7 -> saturation everywhere
    axi_write(4'h8, 32'h07FF_FFFF);
    for (int p = 0; p < W*W; p++) img[p] = 255;
    axi_write(4'h0, 32'h1);
    send_pixels(W*W);
    check_frame(1);
    axi_read(4'h4, rd); chk("status done 2", rd, 2);
    axi_write(4'h0, 32'h0);

    // Frame 3: random pixels and weights, random sink backpressure
    for (int k = 0; k < 9; k++) wts[k] = int'($urandom_range(0, 7));
    packed_w = pack_wts();
    axi_write(4'h8, packed_w);
    axi_read(4'h8, rd); chk("random filter readback", rd, packed_w);
    for (int p = 0; p < W*W; p++) img[p] = int'($urandom_range(0, 255));
    rand_ready = 1'b1;
    axi_write(4'h0, 32'h1);
    send_pixels(W*W);
    check_frame(2);
    rand_ready = 1'b0;
    axi_read(4'h4, rd); chk("status done 3", rd, 2);
    axi_write(4'h0, 32'h0);
    axi_read(4'h4, rd); chk("status idle 3", rd, 0);

    // Reset in the middle of a frame with results waiting in the FIFO
    cap_en = 1'b0; sink_ready = 1'b0;
    axi_write(4'h0, 32'h1);
    send_pixels(2*W + 3);
    repeat (2) @(negedge clk);
    chk("pre-reset m_tvalid", m_axis_tvalid, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("midrst m_tvalid", m_axis_tvalid, 0);
    chk("midrst m_tdata", m_axis_tdata, 0);
    chk("midrst m_tuser", m_axis_tuser, 0);
    chk("midrst m_tlast", m_axis_tlast, 0);
    chk("midrst s_tready", s_axis_tready, 0);
    chk("midrst awready", awready, 0);
    chk("midrst wready", wready, 0);
    chk("midrst arready", arready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    sink_ready = 1'b1;
    axi_read(4'h4, rd); chk("status after midrst", rd, 0);
    axi_read(4'h0, rd); chk("ctrl after midrst", rd, 0);
    axi_read(4'h8, rd); chk("filter after midrst", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
